// File: rtl/pcm_arb_pkg.sv
// Shared types and constants for the PCM memory arbiter.
// Holds the FSM state encoding and bus-width constants.
package pcm_arb_pkg;

    localparam int          CPU_AW   = 20;
    localparam int          DATA_W   = 16;
    localparam logic [15:0] OOR_DATA = 16'hFFFF;
    localparam logic [1:0]  BE_ALL   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/pcm_mm_arbiter_if.sv
// CPU-side request bus and PCM Avalon-MM slave bus of the arbiter.
// master = arbiter side, slave = requesters and memory side.
interface pcm_mm_arbiter_if #(
    parameter int NUM_CPU = 4,
    parameter int MEM_AW  = 11
);
    import pcm_arb_pkg::*;

    logic [NUM_CPU-1:0]             cpu_req;
    logic [NUM_CPU-1:0]             cpu_write;
    logic [NUM_CPU-1:0][CPU_AW-1:0] cpu_addr;
    logic [NUM_CPU-1:0][DATA_W-1:0] cpu_data_in;
    logic [NUM_CPU-1:0]             cpu_ready;
    logic [NUM_CPU-1:0][DATA_W-1:0] cpu_data_out;

    logic [MEM_AW-1:0]              pcm_mem_mm_address;
    logic                           pcm_mem_mm_chipselect;
    logic                           pcm_mem_mm_clken;
    logic                           pcm_mem_mm_write;
    logic [DATA_W-1:0]              pcm_mem_mm_writedata;
    logic [1:0]                     pcm_mem_mm_byteenable;
    logic [DATA_W-1:0]              pcm_mem_mm_readdata;

    modport master (
        input  cpu_req, cpu_write, cpu_addr, cpu_data_in,
        input  pcm_mem_mm_readdata,
        output cpu_ready, cpu_data_out,
        output pcm_mem_mm_address, pcm_mem_mm_chipselect,
        output pcm_mem_mm_clken, pcm_mem_mm_write,
        output pcm_mem_mm_writedata, pcm_mem_mm_byteenable
    );

    modport slave (
        output cpu_req, cpu_write, cpu_addr, cpu_data_in,
        output pcm_mem_mm_readdata,
        input  cpu_ready, cpu_data_out,
        input  pcm_mem_mm_address, pcm_mem_mm_chipselect,
        input  pcm_mem_mm_clken, pcm_mem_mm_write,
        input  pcm_mem_mm_writedata, pcm_mem_mm_byteenable
    );

endinterface

// File: rtl/pcm_rr_select.sv
// Combinational requester select: round-robin from i_ptr with mask,
// or lowest-index fixed priority when PCM_ARB_FIXED_PRIO_EN is defined.
module pcm_rr_select #(
    parameter int NUM_CPU = 4,
    parameter int IW      = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1
) (
    input  logic [NUM_CPU-1:0] i_req,
    input  logic [NUM_CPU-1:0] i_mask,
    input  logic [IW-1:0]      i_ptr,
    output logic               o_valid,
    output logic [IW-1:0]      o_grant
);

`ifdef PCM_ARB_FIXED_PRIO_EN
    logic w_unused;
    assign w_unused = ^{i_mask, i_ptr};

    always_comb begin
        o_valid = 1'b0;
        o_grant = '0;
        for (int i = NUM_CPU - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_grant = IW'(i);
            end
        end
    end
`else
    logic [NUM_CPU-1:0] w_cand;
    assign w_cand = i_req & ~i_mask;

    // Descending scan so the smallest offset from i_ptr wins.
    always_comb begin
        o_valid = 1'b0;
        o_grant = '0;
        for (int k = NUM_CPU - 1; k >= 0; k--) begin
            if (w_cand[(int'(i_ptr) + k) % NUM_CPU]) begin
                o_valid = 1'b1;
                o_grant = IW'((int'(i_ptr) + k) % NUM_CPU);
            end
        end
    end
`endif

endmodule

// File: rtl/pcm_mm_arbiter.sv
// Serialises NUM_CPU requesters onto the PCM Avalon-MM slave port.
// Define PCM_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module pcm_mm_arbiter
    import pcm_arb_pkg::*;
#(
    parameter int NUM_CPU      = 4,
    parameter int READ_LATENCY = 1,
    parameter int MEM_AW       = 11
) (
    input  logic              clk,
    input  logic              reset,
    pcm_mm_arbiter_if.master  bus
);

    localparam int IW = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;

    state_t                         r_state;
    logic [IW-1:0]                  r_id;
    logic [IW-1:0]                  r_ptr;
    logic                           r_write;
    logic                           r_mask_en;
    logic [1:0]                     r_wcnt;
    logic [NUM_CPU-1:0]             r_ready;
    logic [NUM_CPU-1:0][DATA_W-1:0] r_dout;
    logic [MEM_AW-1:0]              r_mm_addr;
    logic                           r_mm_cs;
    logic                           r_mm_wr;
    logic [DATA_W-1:0]              r_mm_wd;
    logic [1:0]                     r_mm_be;

    logic [NUM_CPU-1:0]             w_mask;
    logic                           w_valid;
    logic [IW-1:0]                  w_grant;
    logic [CPU_AW-1:0]              w_addr;
    logic                           w_wr;
    logic                           w_oor;

    assign w_mask = r_mask_en ? (NUM_CPU'(1) << r_id) : '0;
    assign w_addr = bus.cpu_addr[w_grant];
    assign w_wr   = bus.cpu_write[w_grant];
    assign w_oor  = |w_addr[CPU_AW-1:MEM_AW];

    pcm_rr_select #(
        .NUM_CPU (NUM_CPU),
        .IW      (IW)
    ) u_sel (
        .i_req   (bus.cpu_req),
        .i_mask  (w_mask),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_grant (w_grant)
    );

    // r_ptr is the next start index, so reset favours CPU0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_id      <= '0;
            r_ptr     <= '0;
            r_write   <= 1'b0;
            r_mask_en <= 1'b0;
            r_wcnt    <= '0;
            r_ready   <= '0;
            r_dout    <= '0;
            r_mm_addr <= '0;
            r_mm_cs   <= 1'b0;
            r_mm_wr   <= 1'b0;
            r_mm_wd   <= '0;
            r_mm_be   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_mask_en <= 1'b0;
                    if (w_valid) begin
                        r_id    <= w_grant;
                        r_write <= w_wr;
                        if (w_oor) begin
                            r_state          <= DONE;
                            r_ready[w_grant] <= 1'b1;
                            if (!w_wr)
                                r_dout[w_grant] <= OOR_DATA;
                        end else begin
                            r_state   <= ACCESS;
                            r_mm_cs   <= 1'b1;
                            r_mm_addr <= w_addr[MEM_AW-1:0];
                            r_mm_wr   <= w_wr;
                            r_mm_wd   <= bus.cpu_data_in[w_grant];
                            r_mm_be   <= BE_ALL;
                        end
                    end
                end
                ACCESS: begin
                    r_mm_cs   <= 1'b0;
                    r_mm_addr <= '0;
                    r_mm_wr   <= 1'b0;
                    r_mm_wd   <= '0;
                    r_mm_be   <= '0;
                    r_wcnt    <= '0;
                    if (r_write) begin
                        r_state       <= DONE;
                        r_ready[r_id] <= 1'b1;
                    end else if (READ_LATENCY == 1) begin
                        r_state <= CAPTURE;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_wcnt == 2'(READ_LATENCY - 2))
                        r_state <= CAPTURE;
                    else
                        r_wcnt <= r_wcnt + 2'd1;
                end
                CAPTURE: begin
                    r_dout[r_id]  <= bus.pcm_mem_mm_readdata;
                    r_ready[r_id] <= 1'b1;
                    r_state       <= DONE;
                end
                DONE: begin
                    r_ready   <= '0;
                    r_mask_en <= 1'b1;
                    r_state   <= IDLE;
                    r_ptr     <= (r_id == IW'(NUM_CPU - 1)) ? '0 : r_id + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_ready             = r_ready;
    assign bus.cpu_data_out          = r_dout;
    assign bus.pcm_mem_mm_address    = r_mm_addr;
    assign bus.pcm_mem_mm_chipselect = r_mm_cs;
    assign bus.pcm_mem_mm_clken      = r_mm_cs;
    assign bus.pcm_mem_mm_write      = r_mm_wr;
    assign bus.pcm_mem_mm_writedata  = r_mm_wd;
    assign bus.pcm_mem_mm_byteenable = r_mm_be;

endmodule

// File: tb/tb_pcm_mm_arbiter.sv
// Randomised scoreboard bench for pcm_mm_arbiter with a PCM memory model.
// Reference grants come from a transaction-level arbitration model.
module tb_pcm_mm_arbiter;
    import pcm_arb_pkg::*;

    localparam int N  = 4;
    localparam int RL = 3;
    localparam int AW = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pcm_mm_arbiter_if #(.NUM_CPU(N), .MEM_AW(AW)) bus ();

    pcm_mm_arbiter #(
        .NUM_CPU      (N),
        .READ_LATENCY (RL),
        .MEM_AW       (AW)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    logic [N-1:0]         drv_req = '0;
    logic [N-1:0]         drv_wr = '0;
    logic [N-1:0][19:0]   drv_addr = '0;
    logic [N-1:0][15:0]   drv_wd = '0;

    assign bus.cpu_req     = drv_req;
    assign bus.cpu_write   = drv_wr;
    assign bus.cpu_addr    = drv_addr;
    assign bus.cpu_data_in = drv_wd;

    // Memory slave: readdata appears RL cycles after the access cycle.
    logic [15:0] smem [2048];
    logic [15:0] pipe [RL];

    initial begin
        for (int i = 0; i < 2048; i++) smem[i] = 16'h0;
        for (int i = 0; i < RL; i++) pipe[i] = 16'h0;
    end

    always @(posedge clk) begin
        if (bus.pcm_mem_mm_chipselect && bus.pcm_mem_mm_clken) begin
            if (bus.pcm_mem_mm_write) begin
                if (bus.pcm_mem_mm_byteenable[0])
                    smem[bus.pcm_mem_mm_address][7:0] <=
                        bus.pcm_mem_mm_writedata[7:0];
                if (bus.pcm_mem_mm_byteenable[1])
                    smem[bus.pcm_mem_mm_address][15:8] <=
                        bus.pcm_mem_mm_writedata[15:8];
            end
        end
        for (int k = RL - 1; k > 0; k--) pipe[k] <= pipe[k-1];
        pipe[0] <= (bus.pcm_mem_mm_chipselect && !bus.pcm_mem_mm_write)
                   ? smem[bus.pcm_mem_mm_address] : 16'hDEAD;
    end

    assign bus.pcm_mem_mm_readdata = pipe[RL-1];

    typedef struct {
        int          cpu;
        bit          wr;
        bit          oor;
        logic [10:0] a;
        logic [15:0] wd;
        logic [15:0] rd;
        int          gcyc;
        int          rcyc;
    } exp_t;

    exp_t        q[$];
    int          served[$];
    int          cyc = 0;
    int          free_at = 0;
    int          mask_id = -1;
    int          ptr = 0;
    int          acc_cnt = 0;
    logic [15:0] mmem [2048];
    logic [15:0] exp_dout [N];
    bit   [N-1:0] ready_seen = '0;
    bit   [N-1:0] linger = '0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference arbiter: one transaction at a time, latency table,
    // round-robin from the CPU after the last served, mask for one cycle.
    initial begin
        int w;
        int idx;
        int lat;
        exp_t e;
        for (int i = 0; i < 2048; i++) mmem[i] = 16'h0;
        for (int i = 0; i < N; i++) exp_dout[i] = 16'h0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst_n && cyc >= free_at) begin
                w = -1;
`ifdef PCM_ARB_FIXED_PRIO_EN
                for (int i = 0; i < N; i++)
                    if (w < 0 && drv_req[i]) w = i;
`else
                for (int k = 0; k < N; k++) begin
                    idx = (ptr + k) % N;
                    if (w < 0 && drv_req[idx] &&
                        !(cyc == free_at && idx == mask_id))
                        w = idx;
                end
`endif
                if (w >= 0) begin
                    e.cpu  = w;
                    e.wr   = drv_wr[w];
                    e.oor  = (drv_addr[w][19:11] != 9'h0);
                    e.a    = drv_addr[w][10:0];
                    e.wd   = drv_wd[w];
                    e.rd   = e.oor ? OOR_DATA : mmem[e.a];
                    lat    = e.oor ? 1 : (e.wr ? 2 : 2 + RL);
                    e.gcyc = cyc;
                    e.rcyc = cyc + lat - 1;
                    if (e.wr && !e.oor) mmem[e.a] = e.wd;
                    q.push_back(e);
                    free_at = cyc + lat + 1;
                    mask_id = w;
                    ptr     = (w + 1) % N;
                end
            end
        end
    end

    // Monitor: compares bus activity and completions against the queue.
    initial begin
        exp_t e;
        logic [N-1:0] exp_rdy;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.pcm_mem_mm_chipselect) begin
                    if (q.size() == 0 || q[0].oor || q[0].gcyc != cyc) begin
                        chk("mm_cs_unexpected", 1, 0);
                    end else begin
                        acc_cnt++;
                        chk("mm_addr", bus.pcm_mem_mm_address, q[0].a);
                        chk("mm_write", bus.pcm_mem_mm_write, q[0].wr);
                        chk("mm_wdata", bus.pcm_mem_mm_writedata, q[0].wd);
                        chk("mm_be", bus.pcm_mem_mm_byteenable, BE_ALL);
                        chk("mm_clken", bus.pcm_mem_mm_clken, 1);
                    end
                end else begin
                    chk("mm_idle",
                        {bus.pcm_mem_mm_clken, bus.pcm_mem_mm_write,
                         bus.pcm_mem_mm_byteenable,
                         bus.pcm_mem_mm_address},
                        0);
                end
                exp_rdy = '0;
                if (q.size() != 0 && q[0].rcyc == cyc)
                    exp_rdy[q[0].cpu] = 1'b1;
                chk("ready", bus.cpu_ready, exp_rdy);
                if (q.size() != 0 && q[0].rcyc == cyc) begin
                    e = q.pop_front();
                    if (!e.wr) exp_dout[e.cpu] = e.rd;
                    for (int i = 0; i < N; i++)
                        chk("data_out", bus.cpu_data_out[i], exp_dout[i]);
                    chk("access_count", acc_cnt, e.oor ? 0 : 1);
                    acc_cnt = 0;
                    served.push_back(e.cpu);
                    ready_seen[e.cpu] = 1'b1;
                end
            end
        end
    end

    task automatic issue(input int i, input bit wr, input logic [19:0] a,
                         input logic [15:0] d);
        drv_wr[i]   = wr;
        drv_addr[i] = a;
        drv_wd[i]   = d;
        drv_req[i]  = 1'b1;
    endtask

    task automatic new_req(input int i);
        logic [19:0] a;
        if ($urandom % 8 == 0)
            a = {9'($urandom_range(1, 511)), 11'($urandom)};
        else
            a = {9'h0, (($urandom % 2) != 0) ? 7'h7F : 7'h00, 4'($urandom)};
        issue(i, 1'($urandom), a, 16'($urandom));
    endtask

    task automatic wait_served(input int i);
        int t;
        t = 0;
        while (!ready_seen[i] && t < 60) begin
            @(posedge clk);
            t++;
        end
        if (!ready_seen[i]) chk("serve_timeout", 0, 1);
        #1;
        ready_seen[i] = 1'b0;
        drv_req[i] = 1'b0;
    endtask

    task automatic flush_model();
        q.delete();
        for (int i = 0; i < N; i++) exp_dout[i] = 16'h0;
        acc_cnt = 0;
        ready_seen = '0;
        linger = '0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        free_at = cyc + 1;
        mask_id = -1;
        ptr = 0;
    endtask

    task automatic check_zero_outputs(input string nm);
        chk({nm, "_ready"}, bus.cpu_ready, 0);
        for (int i = 0; i < N; i++)
            chk({nm, "_dout"}, bus.cpu_data_out[i], 0);
        chk({nm, "_mm"},
            {bus.pcm_mem_mm_chipselect, bus.pcm_mem_mm_clken,
             bus.pcm_mem_mm_write, bus.pcm_mem_mm_byteenable,
             bus.pcm_mem_mm_address},
            0);
        chk({nm, "_wdata"}, bus.pcm_mem_mm_writedata, 0);
    endtask

`ifdef PCM_ARB_FIXED_PRIO_EN
    int exp_order [5] = '{0, 0, 1, 2, 3};
`else
    int exp_order [5] = '{0, 1, 2, 3, 0};
`endif

    initial begin
        int base;
        int t;
        int g;
        int m;
        bit reissued;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        release_reset();

        // All four read at once; CPU0 re-requests straight away.
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) issue(i, 1'b0, 20'h10 + 20'(i), 16'h0);
        base = served.size();
        reissued = 1'b0;
        t = 0;
        while (served.size() < base + 5 && t < 100) begin
            @(posedge clk); #1;
            t++;
            for (int i = 0; i < N; i++) begin
                if (ready_seen[i]) begin
                    ready_seen[i] = 1'b0;
                    if (i == 0 && !reissued) reissued = 1'b1;
                    else drv_req[i] = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
        drv_req = '0;
        ready_seen = '0;
        chk("order_count", served.size() - base, 5);
        for (int k = 0; k < 5; k++)
            if (served.size() > base + k)
                chk("grant_order", served[base+k], exp_order[k]);

        // Write then read back through CPU0, then an out-of-range read.
        repeat (3) @(posedge clk); #1;
        issue(0, 1'b1, 20'h00010, 16'h0FF0);
        wait_served(0);
        issue(0, 1'b0, 20'h00010, 16'h0);
        wait_served(0);
        @(negedge clk);
        chk("readback", bus.cpu_data_out[0], 16'h0FF0);
        @(posedge clk); #1;
        issue(2, 1'b0, 20'hFFFFF, 16'h0);
        wait_served(2);
        @(negedge clk);
        chk("oor_data", bus.cpu_data_out[2], 16'hFFFF);

        // Random traffic with drop / linger / immediate re-request.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (ready_seen[i]) begin
                    ready_seen[i] = 1'b0;
                    m = int'($urandom % 3);
                    if (m == 0) drv_req[i] = 1'b0;
                    else if (m == 1) linger[i] = 1'b1;
                    else new_req(i);
                end else if (linger[i]) begin
                    linger[i] = 1'b0;
                    drv_req[i] = 1'b0;
                end else if (!drv_req[i] && ($urandom % 4) == 0) begin
                    new_req(i);
                end
            end
        end

        t = 0;
        while ((drv_req != 0 || q.size() != 0) && t < 400) begin
            @(posedge clk); #1;
            t++;
            for (int i = 0; i < N; i++) begin
                if (ready_seen[i] || linger[i]) begin
                    ready_seen[i] = 1'b0;
                    linger[i] = 1'b0;
                    drv_req[i] = 1'b0;
                end
            end
        end
        chk("drain_queue", q.size(), 0);
        chk("drain_req", drv_req, 0);

        // Reset in the first WAIT cycle of a read, then re-grant.
        repeat (3) @(posedge clk); #1;
        issue(1, 1'b0, 20'h00010, 16'h0);
        t = 0;
        while (q.size() == 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("mid_grant", q.size(), 1);
        if (q.size() != 0) begin
            g = q[0].gcyc;
            while (cyc < g + 1) @(negedge clk);
        end
        #1;
        rst_n = 1'b0;
        flush_model();
        #1;
        check_zero_outputs("midreset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("heldreset");
        release_reset();
        wait_served(1);
        @(negedge clk);
        chk("regrant_cpu", served[served.size()-1], 1);
        chk("regrant_data", bus.cpu_data_out[1], mmem[11'h010]);

        repeat (5) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++)
            chk("final_dout", bus.cpu_data_out[i], exp_dout[i]);
        chk("final_queue", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/pcm_mm_arbiter.md
Name: pcm_mm_arbiter

Overview:
- Shares the single PCM on-chip memory Avalon-MM slave port (11-bit word address, 16-bit data) among NUM_CPU requesting CPU ports.
- Each CPU presents a request with write flag, 20-bit address and data, and receives a one-cycle ready pulse plus held read data.
- Sits between the CPU-side PCM interfaces and the pcm_mem_mm port in the SoC.
- Serialises accesses, one outstanding transaction at a time.

Parameters:
- NUM_CPU, 4: number of requester ports.
- READ_LATENCY, 1: slave readdata latency in cycles after the access cycle (1..3).
- MEM_AW, 11: memory word-address width. Addresses with bits [19:MEM_AW] nonzero are out of range.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-low
- cpu_req  in  NUM_CPU  per-CPU request, held until ready
- cpu_write  in  NUM_CPU  1=write, 0=read
- cpu_addr  in  NUM_CPU x 20  word address
- cpu_data_in  in  NUM_CPU x 16  write data
- cpu_ready  out  NUM_CPU  one-cycle completion pulse
- cpu_data_out  out  NUM_CPU x 16  last read result per CPU
- pcm_mem_mm_address  out  MEM_AW  slave address
- pcm_mem_mm_chipselect  out  1
- pcm_mem_mm_clken  out  1
- pcm_mem_mm_write  out  1
- pcm_mem_mm_writedata  out  16
- pcm_mem_mm_byteenable  out  2
- pcm_mem_mm_readdata  in  16

Behaviour:
- Reset (async, low): state=IDLE; rr pointer=0; all outputs 0, including every cpu_data_out and cpu_ready.
- FSM states: IDLE, ACCESS, WAIT, CAPTURE, DONE.
- IDLE:
  - If any unmasked cpu_req is set, pick a winner round-robin, starting at (last_grant+1) mod NUM_CPU.
  - Latch the winner's id, write, addr and data_in.
  - In range: go to ACCESS. Out of range: go to DONE with an OOR flag set.
- ACCESS (exactly 1 cycle):
  - chipselect=1, clken=1, address=addr[MEM_AW-1:0], write=latched write, writedata=latched data, byteenable=2'b11.
  - Write: go to DONE. Read: go to WAIT.
- WAIT:
  - Counts READ_LATENCY-1 cycles, with all mm outputs 0.
  - Zero cycles when READ_LATENCY=1: goes directly to CAPTURE.
- CAPTURE: cpu_data_out[id] <= pcm_mem_mm_readdata; go to DONE.
- DONE:
  - cpu_ready[id]=1 for this cycle only.
  - If OOR and the access is a read, cpu_data_out[id] <= 16'hFFFF. An OOR write is dropped silently.
  - last_grant <= id; go to IDLE.
- Latency, counted from the IDLE grant cycle to the ready cycle:
  - Write: 2 cycles.
  - Read: 3+READ_LATENCY-1 cycles (3 cycles when READ_LATENCY=1).
  - OOR: 1 cycle.
- Mask rule: in the IDLE cycle that immediately follows DONE, the just-served CPU is masked. This allows the requester a one-cycle delay in dropping cpu_req.
- No per-CPU timeout. A request is never dropped once granted.
- Requests arriving mid-transaction wait. Inputs are sampled only in IDLE.
- Outputs:
  - cpu_data_out[i] holds its value until the next read completion for CPU i.
  - mm outputs are 0 outside ACCESS.
- Reset mid-operation: the transaction is aborted, no ready is issued, and there is no retry. A memory write already issued in ACCESS is not undone.

Optional Feature:
- Macro: PCM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The rr pointer and the mask rule are removed; the just-served CPU is not masked.
- Undefined (default): round-robin with masking as above.

Decomposition:
- Package pcm_arb_pkg holds:
  - state enum typedef (IDLE, ACCESS, WAIT, CAPTURE, DONE);
  - constants CPU_AW=20, DATA_W=16, OOR_DATA=16'hFFFF, BE_ALL=2'b11.
- Sub-module pcm_rr_select: combinational, with inputs req vector, mask and last_grant, and outputs valid and grant index.
  - The PCM_ARB_FIXED_PRIO_EN switch lives inside it.

Test Plan:
- CPU0 write addr 20'h00010 data 16'h0FF0 → one ACCESS cycle with address 11'h010, write=1, byteenable=2'b11; cpu_ready[0] pulses 2 cycles after grant.
- CPU0 read addr 20'h00010 (READ_LATENCY=1) → cpu_data_out[0]=16'h0FF0; cpu_ready[0] pulses 3 cycles after grant, one cycle wide.
- All four CPUs request simultaneously after reset (reads) → grants in order 0,1,2,3. CPU0 re-requests immediately → next grant after 3 is 0, and CPU0 never receives back-to-back grants while others wait.
- CPU2 read addr 20'hFFFFF → no chipselect; cpu_ready[2] 1 cycle after grant; cpu_data_out[2]=16'hFFFF.
- Reset asserted during WAIT with READ_LATENCY=3 → all outputs 0 asynchronously, no cpu_ready. After release, the same held request is re-granted and completes.
- PCM_ARB_FIXED_PRIO_EN defined, CPU0 and CPU3 holding requests continuously → CPU3 is never granted while CPU0 requests.
